// File: rtl/ldpc_parity_sequencer_if.sv
// Valid/ready stream carrying one W-bit word per beat; used for both the
// sub-block input and the parity output of the parity sequencer.
interface ldpc_parity_sequencer_if #(
    parameter int W = 5
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ldpc_parity_sequencer.sv
// Sequencer for the QC-LDPC parity-shift accumulator: clear, CYCLE beats, capture, output.
// Define PARITY_SEQ_LASTCHK_EN to enable the in_last length check on err_len.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  CLEAR   | one cycle, accumulator held in clear, beat counter zeroed
//  ACCUM   | accepting sub-blocks, each accepted beat clocks the accumulator
//  CAPTURE | accumulator parity is final, latch it into out_parity
//  OUTPUT  | parity word offered downstream until handshake
module ldpc_parity_sequencer #(
    parameter int Z     = 5,
    parameter int CYCLE = 3,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ldpc_parity_sequencer_if.slave  in_s,
    ldpc_parity_sequencer_if.master out_s,
    input  logic                  in_last,
    output logic                  acc_rst,
    output logic                  acc_ce,
    output logic [Z-1:0]          acc_u,
    input  logic [Z-1:0]          acc_parity,
    output logic [CNTW-1:0]       cw_cnt,
    output logic                  err_len
);

    localparam int BLKW = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam logic [BLKW-1:0] LAST_BLK = BLKW'(CYCLE - 1);

`ifdef PARITY_SEQ_LASTCHK_EN
    localparam bit LASTCHK = 1'b1;
`else
    localparam bit LASTCHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_ACCUM   = 2'd1,
        S_CAPTURE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BLKW-1:0] blk_q, blk_d;
    logic            out_valid_q, out_valid_d;
    logic [Z-1:0]    out_parity_q, out_parity_d;
    logic [CNTW-1:0] cw_cnt_q, cw_cnt_d;
    logic            err_len_q, err_len_d;
    logic            in_ready;
    logic            last_beat;

    assign last_beat = (blk_q == LAST_BLK);

    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        cw_cnt_d     = cw_cnt_q;
        err_len_d    = 1'b0;
        in_ready     = 1'b0;
        acc_ce       = 1'b0;
        acc_u        = '0;

        case (state_q)
            S_CLEAR: begin
                blk_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_s.valid) begin
                    acc_ce = 1'b1;
                    acc_u  = in_s.data;
                    // in_last is only reported on; the beat count alone ends the codeword
                    err_len_d = LASTCHK & (in_last != last_beat);
                    if (last_beat) begin
                        state_d = S_CAPTURE;
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                out_parity_d = acc_parity;
                out_valid_d  = 1'b1;
                state_d      = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_s.ready) begin
                    out_valid_d = 1'b0;
                    cw_cnt_d    = cw_cnt_q + 1'b1;
                    state_d     = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            blk_q        <= '0;
            out_valid_q  <= 1'b0;
            out_parity_q <= '0;
            cw_cnt_q     <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            cw_cnt_q     <= cw_cnt_d;
            err_len_q    <= err_len_d;
        end
    end

    // Accumulator is cleared while in reset as well as during CLEAR.
    assign acc_rst    = rst | (state_q == S_CLEAR);
    assign in_s.ready = in_ready;
    assign out_s.valid = out_valid_q;
    assign out_s.data  = out_parity_q;
    assign cw_cnt      = cw_cnt_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_ldpc_parity_sequencer.sv
// Self-checking bench for ldpc_parity_sequencer with a behavioural circulant
// XOR accumulator on the acc_* ports and a parity scoreboard.
module tb_ldpc_parity_sequencer;

    localparam int Z     = 5;
    localparam int CYCLE = 3;
    localparam int CNTW  = 8;

`ifdef PARITY_SEQ_LASTCHK_EN
    localparam int EXP_ERR_PULSES = 1;
    localparam bit LASTCHK = 1'b1;
`else
    localparam int EXP_ERR_PULSES = 0;
    localparam bit LASTCHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_last;
    logic            acc_rst;
    logic            acc_ce;
    logic [Z-1:0]    acc_u;
    logic [Z-1:0]    acc_par;
    logic [CNTW-1:0] cw_cnt;
    logic            err_len;

    ldpc_parity_sequencer_if #(.W(Z)) in_s ();
    ldpc_parity_sequencer_if #(.W(Z)) out_s ();

    ldpc_parity_sequencer #(.Z(Z), .CYCLE(CYCLE), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_s       (in_s),
        .out_s      (out_s),
        .in_last    (in_last),
        .acc_rst    (acc_rst),
        .acc_ce     (acc_ce),
        .acc_u      (acc_u),
        .acc_parity (acc_par),
        .cw_cnt     (cw_cnt),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    // behavioural accumulator: rotate-left by one, XOR in the sub-block
    always_ff @(posedge clk) begin
        if (acc_rst)     acc_par <= '0;
        else if (acc_ce) acc_par <= {acc_par[Z-2:0], acc_par[Z-1]} ^ acc_u;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [Z-1:0] rotl(input logic [Z-1:0] v);
        return {v[Z-2:0], v[Z-1]};
    endfunction

    // scoreboard / monitor state
    logic [Z-1:0] exp_q[$];
    logic [Z-1:0] model_p = '0;
    int           beat = 0;
    int           cyc = 0;
    int           exp_cw = 0;
    int           ce_cnt = 0;
    int           err_cnt = 0;
    int           last_beat_cyc = 0;
    int           first_beat_cyc = 0;
    int           hs_cyc = 0;
    bit           err_pend = 1'b0;
    bit           after_hs = 1'b0;
    bit           prev_stall = 1'b0;
    bit           prev_valid = 1'b0;
    logic [Z-1:0] held_par = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            model_p    = '0;
            beat       = 0;
            exp_cw     = 0;
            err_pend   = 1'b0;
            after_hs   = 1'b0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            check_eq("err_len", err_len, err_pend);
            if (after_hs) check_eq("acc_rst_after_hs", acc_rst, 1);
            after_hs = 1'b0;
            check_eq("acc_ce", acc_ce, in_s.valid & in_s.ready);
            check_eq("acc_u", acc_u, acc_ce ? in_s.data : '0);
            if (out_s.valid) check_eq("in_ready_in_output", in_s.ready, 0);
            if (prev_stall) begin
                check_eq("hold_valid", out_s.valid, 1);
                check_eq("hold_parity", out_s.data, held_par);
            end
            if (out_s.valid && !prev_valid) check_eq("latency", cyc - last_beat_cyc, 2);

            err_pend = 1'b0;
            if (in_s.valid && in_s.ready) begin
                if (beat == 0) first_beat_cyc = cyc;
                err_pend = LASTCHK & (in_last != (beat == CYCLE - 1));
                model_p  = rotl(model_p) ^ in_s.data;
                beat++;
                if (beat == CYCLE) begin
                    exp_q.push_back(model_p);
                    model_p       = '0;
                    beat          = 0;
                    last_beat_cyc = cyc;
                end
            end

            if (out_s.valid && out_s.ready) begin
                if (exp_q.size() == 0) check_eq("spurious_out", out_s.valid, 0);
                else check_eq("parity", out_s.data, exp_q.pop_front());
                check_eq("cw_cnt", cw_cnt, exp_cw);
                exp_cw   = (exp_cw + 1) % (1 << CNTW);
                after_hs = 1'b1;
                hs_cyc   = cyc;
            end

            prev_stall = out_s.valid && !out_s.ready;
            held_par   = out_s.data;
            prev_valid = out_s.valid;
            ce_cnt    += int'(acc_ce);
            err_cnt   += int'(err_len);
        end
    end

    task automatic send_beat(input logic [Z-1:0] d, input logic last);
        int n;
        in_s.valid = 1'b1;
        in_s.data  = d;
        in_last    = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_s.ready && n < 50);
        if (!in_s.ready) check_eq("accept_timeout", in_s.ready, 1);
        @(posedge clk); #1;
        in_s.valid = 1'b0;
        in_s.data  = '0;
        in_last    = 1'b0;
    endtask

    task automatic send_cw(input logic [Z-1:0] d0, input logic [Z-1:0] d1,
                           input logic [Z-1:0] d2, input int gap, input bit bad_first);
        logic [Z-1:0] d [CYCLE];
        d[0] = d0; d[1] = d1; d[2] = d2;
        @(posedge clk); #1;
        for (int i = 0; i < CYCLE; i++) begin
            send_beat(d[i], (i == CYCLE - 1) || (bad_first && i == 0));
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !out_s.valid) && n < 60);
        if (out_s.valid) check_eq("drain_timeout", out_s.valid, 0);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_acc_rst", acc_rst, 1);
        check_eq("rst_in_ready", in_s.ready, 0);
        check_eq("rst_acc_ce", acc_ce, 0);
        check_eq("rst_acc_u", acc_u, 0);
        check_eq("rst_out_valid", out_s.valid, 0);
        check_eq("rst_out_parity", out_s.data, 0);
        check_eq("rst_cw_cnt", cw_cnt, 0);
        check_eq("rst_err_len", err_len, 0);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        in_s.valid  = 1'b0;
        in_s.data   = '0;
        in_last     = 1'b0;
        out_s.ready = 1'b0;

        // reset and the single CLEAR cycle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("clear_acc_rst", acc_rst, 1);
        check_eq("clear_in_ready", in_s.ready, 0);
        @(negedge clk);
        check_eq("accum_acc_rst", acc_rst, 0);
        check_eq("accum_in_ready", in_s.ready, 1);

        // back-to-back codeword
        out_s.ready = 1'b1;
        ce_cnt = 0;
        send_cw(5'h01, 5'h02, 5'h04, 0, 1'b0);
        wait_done();
        check_eq("b2b_ce_count", ce_cnt, 3);
        check_eq("b2b_cw_cnt", cw_cnt, 1);

        // gaps between beats, output held off for 4 cycles
        out_s.ready = 1'b0;
        send_cw(5'h13, 5'h0a, 5'h1f, 2, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_s.valid && n < 40);
        check_eq("gap_out_valid", out_s.valid, 1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        in_s.valid  = 1'b1;
        in_s.data   = 5'h05;
        out_s.ready = 1'b1;
        send_cw(5'h05, 5'h11, 5'h07, 0, 1'b0);
        check_eq("simul_accept_delay", first_beat_cyc - hs_cyc, 2);
        wait_done();
        check_eq("gap_cw_cnt", cw_cnt, 3);

        // in_last asserted early on beat 1
        err_cnt = 0;
        send_cw(5'h03, 5'h0c, 5'h18, 0, 1'b1);
        wait_done();
        check_eq("err_len_pulses", err_cnt, EXP_ERR_PULSES);
        check_eq("lenchk_cw_cnt", cw_cnt, 4);

        // reset after beat 2 of a codeword
        @(posedge clk); #1;
        send_beat(5'h1e, 1'b0);
        send_beat(5'h15, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        send_cw(5'h09, 5'h00, 5'h12, 0, 1'b0);
        wait_done();
        check_eq("post_rst_cw_cnt", cw_cnt, 1);

        // remaining codewords to wrap the counter (256 since the reset)
        for (int k = 1; k < 256; k++) begin
            send_cw(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 0, 1'b0);
        end
        wait_done();
        check_eq("cw_wrap", cw_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ldpc_parity_sequencer.md
# ldpc_parity_sequencer

Controller for the QC-LDPC encoder's parity-shift accumulator. It accepts Z-bit information sub-blocks over a valid/ready stream and drives the accumulator's clear, enable and data inputs for exactly CYCLE beats per codeword. It then captures the accumulator's parity word and presents it on a valid/ready output stream. It sits between the message buffer and the parity accumulator and owns all accumulator sequencing.

## Interface
- `Z`, 5: sub-block (circulant) width in bits.
- `CYCLE`, 3: information sub-blocks per codeword; must be ≥1.
- `CNTW`, 8: width of the codeword counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sub-block offered.
- `in_ready`  out  1  controller accepts a sub-block this cycle.
- `in_data`  in  Z  information sub-block.
- `in_last`  in  1  producer marks the final sub-block of a codeword.
- `acc_rst`  out  1  synchronous clear to the accumulator.
- `acc_ce`  out  1  accumulator enable.
- `acc_u`  out  Z  accumulator data input.
- `acc_parity`  in  Z  accumulator parity output.
- `out_valid`  out  1  parity word available.
- `out_ready`  in  1  consumer accepts the parity word.
- `out_parity`  out  Z  captured parity word.
- `cw_cnt`  out  CNTW  count of completed codewords; wraps modulo 2^CNTW.
- `err_len`  out  1  one-cycle pulse when `in_last` disagrees with the beat count.

## Operation
- **States:** CLEAR, ACCUM, CAPTURE, OUTPUT.
- **Reset:** the block enters CLEAR with all outputs at these values:
  - `in_ready`=0, `acc_ce`=0, `acc_u`=0, `out_valid`=0, `out_parity`=0, `cw_cnt`=0, `err_len`=0.
  - `acc_rst`=1; `acc_rst` is combinationally `rst | (state==CLEAR)`.
- **CLEAR:** lasts one cycle with `acc_rst`=1. Beat counter `blk` is reset to 0. Next state is ACCUM.
- **ACCUM:**
  - `in_ready`=1.
  - `acc_ce` = `in_valid & in_ready`, and `acc_u` = `in_data` when `acc_ce`=1, else 0. Both are combinational in the same cycle.
  - Each accepted beat increments `blk`.
  - On the beat with `blk==CYCLE-1`, the next state is CAPTURE.
  - An `in_valid`=0 cycle holds the state with `acc_ce`=0.
- **CAPTURE:** lasts one cycle with `in_ready`=0. On its edge, `out_parity` ← `acc_parity` and `out_valid` ← 1. Next state is OUTPUT.
- **OUTPUT:**
  - `out_valid`=1; `out_parity` is stable until the handshake.
  - On `out_valid & out_ready`: `out_valid` ← 0, `cw_cnt` ← `cw_cnt`+1, next state is CLEAR.
- **Beat count:** the beat count is authoritative; `in_last` never ends or extends a codeword.
- **Width rules:**
  - `blk` is ceil(log2(CYCLE)) bits, minimum 1.
  - `cw_cnt` wraps from 2^CNTW−1 to 0.

## Timing
- **Accumulator:** it updates on the edge of each accepted beat, so `acc_parity` is final on the cycle after the last beat (the CAPTURE cycle).
- **Latency:** from the last accepted beat to `out_valid`=1 is 2 cycles.
- **Throughput:** minimum cycle count per codeword is CYCLE+3 (CLEAR + CYCLE beats + CAPTURE + 1 OUTPUT cycle), reached when `out_ready` is held high.
- **Backpressure:** `in_ready`=0 outside ACCUM. `out_ready` is ignored outside OUTPUT.
- **Simultaneous events:** an `out_ready` handshake and `in_valid` in the same cycle are legal. The input beat is not accepted until ACCUM, 2 cycles later.
- **Reset mid-operation:** asynchronous `rst` returns the block to CLEAR immediately and discards any partial codeword and any pending output. `cw_cnt` clears.

## Configuration
- **`PARITY_SEQ_LASTCHK_EN` defined:** `err_len` pulses for one cycle after any accepted beat where `in_last` ≠ (`blk==CYCLE-1`). Sequencing is unaffected.
- **Undefined:** `in_last` is ignored and `err_len` is tied to 0.

## Test plan
All scenarios use Z=5, CYCLE=3, with the bench driving a behavioural circulant XOR-accumulator model on the `acc_*` ports.
- **Reset:** release `rst` → `acc_rst`=1 for exactly 1 cycle, then `in_ready`=1; `out_valid`=0, `cw_cnt`=0.
- **Back-to-back codeword:** with `out_ready`=1, stream sub-blocks 5'h01, 5'h02, 5'h04 →
  - `acc_ce` is high on exactly 3 cycles;
  - `out_valid` rises 2 cycles after the third beat, with `out_parity` equal to the model value;
  - `cw_cnt`=1;
  - the next `acc_rst` follows 1 cycle after the handshake.
- **Gaps and backpressure:** insert `in_valid`=0 gaps between beats and hold `out_ready`=0 for 4 cycles →
  - `acc_ce` is low during the gaps;
  - `out_valid` and `out_parity` are held stable;
  - `in_ready`=0 throughout OUTPUT.
- **Wrap-around:** run 256 codewords → `cw_cnt` wraps to 0; every parity word matches the model.
- **Reset mid-operation:** assert `rst` after beat 2 → outputs return to their reset values; the next codeword's parity excludes the aborted beats.
- **Length check, with `PARITY_SEQ_LASTCHK_EN`:** set `in_last`=1 on beat 1 → `err_len` pulses once and the codeword still completes after 3 beats. Without the macro, `err_len` stays 0.
